// File: rtl/pc_fetch_sequencer_pkg.sv
// rtl/pc_fetch_sequencer_pkg.sv - shared states, predictor counter values and reset default for the fetch sequencer
package pc_fetch_sequencer_pkg;

    typedef logic [1:0] fetch_state_t;

    // Fetch sequencer states
    localparam fetch_state_t ST_INIT    = 2'd0;
    localparam fetch_state_t ST_RUN     = 2'd1;
    localparam fetch_state_t ST_HOLD    = 2'd2;
    localparam fetch_state_t ST_RECOVER = 2'd3;

    // Two-bit saturating direction counter values
    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// rtl/pc_fetch_sequencer_if.sv - fetch-stage bus: stall/imem handshake, fetch outputs and execute resolve port
interface pc_fetch_sequencer_if #(
    parameter int PC_W = 32
);
    logic            stall;
    logic            imem_ready;
    logic [PC_W-1:0] pc;
    logic            fetch_valid;
    logic [PC_W-1:0] pred_next;
    logic            resolve_valid;
    logic            resolve_is_branch;
    logic [PC_W-1:0] resolve_pc;
    logic            resolve_taken;
    logic [PC_W-1:0] resolve_target;
    logic [PC_W-1:0] resolve_pred_next;
    logic            flush;

    // The fetch sequencer itself
    modport master (
        input  stall, imem_ready,
        input  resolve_valid, resolve_is_branch, resolve_pc,
        input  resolve_taken, resolve_target, resolve_pred_next,
        output pc, fetch_valid, pred_next, flush
    );

    // Surrounding pipeline: decode, instruction memory and execute
    modport slave (
        output stall, imem_ready,
        output resolve_valid, resolve_is_branch, resolve_pc,
        output resolve_taken, resolve_target, resolve_pred_next,
        input  pc, fetch_valid, pred_next, flush
    );

endinterface

// File: rtl/pc_fetch_sequencer_branch_history_table.sv
// rtl/pc_fetch_sequencer_branch_history_table.sv - direct-mapped 2-bit counter table with target/tag, used when BP_BHT_EN is defined
module branch_history_table
    import pc_fetch_sequencer_pkg::*;
#(
    parameter int PC_W    = 32,
    parameter int ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] lookup_pc,
    output logic [PC_W-1:0] pred_next,
    input  logic            upd_en,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [PC_W-1:0] upd_target
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W - 2;

    logic [1:0]      ctr [ENTRIES];
    logic [PC_W-1:0] tgt [ENTRIES];
    logic [TAG_W-1:0] tag [ENTRIES];
    logic            vld [ENTRIES];

    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic [TAG_W-1:0] rd_tag;
    logic [TAG_W-1:0] wr_tag;
    logic             hit;

    assign rd_idx = lookup_pc[IDX_W+1:2];
    assign rd_tag = lookup_pc[PC_W-1:IDX_W+2];
    assign wr_idx = upd_pc[IDX_W+1:2];
    assign wr_tag = upd_pc[PC_W-1:IDX_W+2];

    // Lookup reads registered state, so a same-cycle update is not visible until the next cycle
    assign hit       = vld[rd_idx] && (tag[rd_idx] == rd_tag) && (ctr[rd_idx] >= WT);
    assign pred_next = hit ? tgt[rd_idx] : lookup_pc + PC_W'(4);

    // Train direction counters on every resolved branch; install target only when taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr[i] <= WNT;
                tgt[i] <= '0;
                tag[i] <= '0;
                vld[i] <= 1'b0;
            end
        end else if (upd_en) begin
            if (upd_taken) begin
                ctr[wr_idx] <= (ctr[wr_idx] == ST) ? ST : ctr[wr_idx] + 2'd1;
                tgt[wr_idx] <= upd_target;
                tag[wr_idx] <= wr_tag;
                vld[wr_idx] <= 1'b1;
            end else begin
                ctr[wr_idx] <= (ctr[wr_idx] == SNT) ? SNT : ctr[wr_idx] - 2'd1;
            end
        end
    end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// rtl/pc_fetch_sequencer.sv - PC owner and fetch FSM with redirect/flush; BP_BHT_EN enables the branch history table
module pc_fetch_sequencer
    import pc_fetch_sequencer_pkg::*;
#(
    parameter int              PC_W         = 32,
    parameter logic [PC_W-1:0] RESET_PC     = PC_W'(DEFAULT_RESET_PC),
    parameter int              FLUSH_CYCLES = 2,
    parameter int              BHT_ENTRIES  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    pc_fetch_sequencer_if.master bus
);

    localparam logic [2:0] BUBBLE_RELOAD = 3'(FLUSH_CYCLES - 1);

    fetch_state_t    state;
    fetch_state_t    state_nxt;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_nxt;
    logic [2:0]      cnt;
    logic [2:0]      cnt_nxt;
    logic [PC_W-1:0] actual_next;
    logic [PC_W-1:0] pred_next;
    logic            res_valid;
    logic            mispredict;

    // Resolve traffic is ignored while reset is held so flush stays low
    assign res_valid   = bus.resolve_valid & ~rst;
    assign actual_next = bus.resolve_taken ? bus.resolve_target : bus.resolve_pc + PC_W'(4);
    assign mispredict  = res_valid && (actual_next != bus.resolve_pred_next);

`ifdef BP_BHT_EN
    branch_history_table #(
        .PC_W    (PC_W),
        .ENTRIES (BHT_ENTRIES)
    ) u_bht (
        .clk        (clk),
        .rst        (rst),
        .lookup_pc  (pc_q),
        .pred_next  (pred_next),
        .upd_en     (res_valid & bus.resolve_is_branch),
        .upd_pc     (bus.resolve_pc),
        .upd_taken  (bus.resolve_taken),
        .upd_target (bus.resolve_target)
    );
`else
    assign pred_next = pc_q + PC_W'(4);
`endif

    // Next-state/next-PC selection: redirect beats hold beats advance
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_q;
        cnt_nxt   = cnt;
        case (state)
            ST_INIT: begin
                state_nxt = ST_RUN;
            end
            ST_RUN, ST_HOLD: begin
                if (mispredict) begin
                    pc_nxt    = actual_next;
                    cnt_nxt   = BUBBLE_RELOAD;
                    state_nxt = ST_RECOVER;
                end else if (bus.stall || !bus.imem_ready) begin
                    state_nxt = ST_HOLD;
                end else begin
                    pc_nxt    = pred_next;
                    state_nxt = ST_RUN;
                end
            end
            ST_RECOVER: begin
                if (mispredict) begin
                    pc_nxt  = actual_next;
                    cnt_nxt = BUBBLE_RELOAD;
                end else if (cnt == 3'd0) begin
                    state_nxt = ST_RUN;
                end else begin
                    cnt_nxt = cnt - 3'd1;
                end
            end
            default: begin
                state_nxt = ST_INIT;
            end
        endcase
    end

    // State, PC and bubble counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_INIT;
            pc_q  <= RESET_PC;
            cnt   <= 3'd0;
        end else begin
            state <= state_nxt;
            pc_q  <= pc_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.fetch_valid = (state == ST_RUN) || (state == ST_HOLD);
    assign bus.pred_next   = pred_next;
    assign bus.flush       = mispredict;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb/tb_pc_fetch_sequencer.sv - self-checking bench for pc_fetch_sequencer (directed plan plus randomized reference model)
module tb_pc_fetch_sequencer;

    localparam int          PC_W   = 32;
    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int          FLUSH  = 2;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    pc_fetch_sequencer_if #(.PC_W(PC_W)) bus();

    pc_fetch_sequencer #(
        .PC_W         (PC_W),
        .RESET_PC     (RST_PC),
        .FLUSH_CYCLES (FLUSH),
        .BHT_ENTRIES  (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_pc;
    int          m_bub;
    bit          m_init;
    int          m_ctr [16];
    logic [31:0] m_tgt [16];
    logic [31:0] m_bpc [16];
    bit          m_val [16];

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_resolve(input logic [31:0] rpc, input logic br, input logic tk,
                               input logic [31:0] tgt, input logic [31:0] pn);
        bus.resolve_valid     = 1'b1;
        bus.resolve_is_branch = br;
        bus.resolve_pc        = rpc;
        bus.resolve_taken     = tk;
        bus.resolve_target    = tgt;
        bus.resolve_pred_next = pn;
    endtask

    task automatic clear_resolve();
        bus.resolve_valid     = 1'b0;
        bus.resolve_is_branch = 1'b0;
        bus.resolve_pc        = '0;
        bus.resolve_taken     = 1'b0;
        bus.resolve_target    = '0;
        bus.resolve_pred_next = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.stall = 1'b0;
        bus.imem_ready = 1'b1;
        set_resolve(32'h104, 1'b1, 1'b1, 32'h200, 32'h108);
        #1;
        checks++; if (bus.pc !== RST_PC) begin failures++; $display("FAIL reset_pc actual=%h expected=%h", bus.pc, RST_PC); end
        checks++; if (bus.fetch_valid !== 1'b0) begin failures++; $display("FAIL reset_valid actual=%b expected=0", bus.fetch_valid); end
        checks++; if (bus.flush !== 1'b0) begin failures++; $display("FAIL reset_flush_masked actual=%b expected=0", bus.flush); end
        next_cycle();
        rst = 1'b0;
        clear_resolve();
        #1;
        checks++; if (bus.fetch_valid !== 1'b0 || bus.pc !== 32'h100) begin failures++; $display("FAIL init_cycle valid=%b pc=%h expected valid=0 pc=100", bus.fetch_valid, bus.pc); end
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            #1;
            checks++;
            if (bus.fetch_valid !== 1'b1 || bus.pc !== 32'h100 + 32'(4 * i)) begin
                failures++;
                $display("FAIL run_seq%0d valid=%b pc=%h expected valid=1 pc=%h", i, bus.fetch_valid, bus.pc, 32'h100 + 32'(4 * i));
            end
        end
        checks++; if (bus.pred_next !== 32'h10C) begin failures++; $display("FAIL pred_seq actual=%h expected=10c", bus.pred_next); end
    endtask

    task automatic test_stall();
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            #1;
            checks++;
            if (bus.pc !== 32'h108 || bus.fetch_valid !== 1'b1) begin
                failures++;
                $display("FAIL stall_hold%0d pc=%h valid=%b expected pc=108 valid=1", i, bus.pc, bus.fetch_valid);
            end
        end
        bus.stall = 1'b0;
        next_cycle();
        #1;
        checks++; if (bus.pc !== 32'h10C) begin failures++; $display("FAIL stall_release actual=%h expected=10c", bus.pc); end
        bus.imem_ready = 1'b0;
        next_cycle();
        #1;
        checks++; if (bus.pc !== 32'h10C || bus.fetch_valid !== 1'b1) begin failures++; $display("FAIL imem_backpressure pc=%h valid=%b expected pc=10c valid=1", bus.pc, bus.fetch_valid); end
        bus.imem_ready = 1'b1;
    endtask

    task automatic test_redirect();
        set_resolve(32'h104, 1'b1, 1'b1, 32'h200, 32'h108);
        #1;
        checks++; if (bus.flush !== 1'b1) begin failures++; $display("FAIL redirect_flush actual=%b expected=1", bus.flush); end
        next_cycle();
        clear_resolve();
        #1;
        checks++; if (bus.flush !== 1'b0) begin failures++; $display("FAIL redirect_flush_clear actual=%b expected=0", bus.flush); end
        for (int i = 0; i < FLUSH; i++) begin
            if (i > 0) begin next_cycle(); #1; end
            checks++;
            if (bus.pc !== 32'h200 || bus.fetch_valid !== 1'b0) begin
                failures++;
                $display("FAIL redirect_bubble%0d pc=%h valid=%b expected pc=200 valid=0", i, bus.pc, bus.fetch_valid);
            end
        end
        next_cycle();
        #1;
        checks++; if (bus.pc !== 32'h200 || bus.fetch_valid !== 1'b1) begin failures++; $display("FAIL redirect_first pc=%h valid=%b expected pc=200 valid=1", bus.pc, bus.fetch_valid); end
        next_cycle();
        #1;
        checks++; if (bus.pc !== 32'h204) begin failures++; $display("FAIL redirect_second actual=%h expected=204", bus.pc); end
    endtask

    task automatic test_recover_redirect();
        set_resolve(32'h204, 1'b1, 1'b1, 32'h200, 32'h208);
        next_cycle();
        clear_resolve();
        #1;
        checks++; if (bus.pc !== 32'h200 || bus.fetch_valid !== 1'b0) begin failures++; $display("FAIL recover_enter pc=%h valid=%b expected pc=200 valid=0", bus.pc, bus.fetch_valid); end
        set_resolve(32'h110, 1'b1, 1'b1, 32'h300, 32'h114);
        #1;
        checks++; if (bus.flush !== 1'b1) begin failures++; $display("FAIL recover_flush actual=%b expected=1", bus.flush); end
        next_cycle();
        clear_resolve();
        #1;
        checks++; if (bus.pc !== 32'h300 || bus.fetch_valid !== 1'b0) begin failures++; $display("FAIL recover_reload0 pc=%h valid=%b expected pc=300 valid=0", bus.pc, bus.fetch_valid); end
        next_cycle();
        #1;
        checks++; if (bus.pc !== 32'h300 || bus.fetch_valid !== 1'b0) begin failures++; $display("FAIL recover_reload1 pc=%h valid=%b expected pc=300 valid=0", bus.pc, bus.fetch_valid); end
        next_cycle();
        #1;
        checks++; if (bus.pc !== 32'h300 || bus.fetch_valid !== 1'b1) begin failures++; $display("FAIL recover_exit pc=%h valid=%b expected pc=300 valid=1", bus.pc, bus.fetch_valid); end
    endtask

    task automatic test_predictor();
        logic [31:0] exp_hot;
`ifdef BP_BHT_EN
        exp_hot = 32'h400;
`else
        exp_hot = 32'h124;
`endif
        for (int i = 0; i < 2; i++) begin
            set_resolve(32'h120, 1'b1, 1'b1, 32'h400, 32'h400);
            #1;
            checks++; if (bus.flush !== 1'b0) begin failures++; $display("FAIL train_noflush%0d actual=%b expected=0", i, bus.flush); end
            next_cycle();
        end
        set_resolve(32'h500, 1'b0, 1'b1, 32'h120, 32'h504);
        next_cycle();
        clear_resolve();
        #1;
        checks++; if (bus.pc !== 32'h120 || bus.pred_next !== exp_hot) begin failures++; $display("FAIL bht_taken pc=%h pred=%h expected pc=120 pred=%h", bus.pc, bus.pred_next, exp_hot); end
        set_resolve(32'h120, 1'b1, 1'b0, 32'h400, 32'h124);
        next_cycle();
        clear_resolve();
        bus.stall = 1'b1;
        #1;
        checks++; if (bus.pc !== 32'h120 || bus.pred_next !== exp_hot) begin failures++; $display("FAIL bht_one_nt pc=%h pred=%h expected pc=120 pred=%h", bus.pc, bus.pred_next, exp_hot); end
        set_resolve(32'h120, 1'b1, 1'b0, 32'h400, 32'h124);
        next_cycle();
        clear_resolve();
        #1;
        checks++; if (bus.pc !== 32'h120 || bus.fetch_valid !== 1'b1 || bus.pred_next !== 32'h124) begin failures++; $display("FAIL bht_two_nt pc=%h valid=%b pred=%h expected pc=120 valid=1 pred=124", bus.pc, bus.fetch_valid, bus.pred_next); end
        set_resolve(32'h120, 1'b1, 1'b1, 32'h400, 32'h400);
        next_cycle();
        set_resolve(32'h120, 1'b1, 1'b1, 32'h400, 32'h400);
        next_cycle();
        clear_resolve();
        #1;
        checks++; if (bus.pred_next !== exp_hot) begin failures++; $display("FAIL bht_retrain actual=%h expected=%h", bus.pred_next, exp_hot); end
    endtask

    task automatic test_reset_in_recover();
        set_resolve(32'h600, 1'b0, 1'b1, 32'h180, 32'h604);
        next_cycle();
        clear_resolve();
        #1;
        checks++; if (bus.pc !== 32'h180 || bus.fetch_valid !== 1'b0) begin failures++; $display("FAIL pre_reset_recover pc=%h valid=%b expected pc=180 valid=0", bus.pc, bus.fetch_valid); end
        set_resolve(32'h700, 1'b0, 1'b1, 32'h800, 32'h704);
        rst = 1'b1;
        #1;
        checks++; if (bus.pc !== RST_PC || bus.fetch_valid !== 1'b0 || bus.flush !== 1'b0) begin failures++; $display("FAIL reset_in_recover pc=%h valid=%b flush=%b expected pc=100 valid=0 flush=0", bus.pc, bus.fetch_valid, bus.flush); end
        next_cycle();
        rst = 1'b0;
        bus.stall = 1'b0;
        clear_resolve();
        next_cycle();
        set_resolve(32'h600, 1'b0, 1'b1, 32'h120, 32'h604);
        next_cycle();
        clear_resolve();
        #1;
        checks++; if (bus.pc !== 32'h120 || bus.pred_next !== 32'h124) begin failures++; $display("FAIL predictor_cleared pc=%h pred=%h expected pc=120 pred=124", bus.pc, bus.pred_next); end
    endtask

    task automatic test_random();
        logic [31:0] r_pc, r_tgt, r_pn, act, exp_pred;
        logic        r_valid, r_br, r_tk, mp;
        int          idx;
        bit          exp_valid;
        rst = 1'b1;
        clear_resolve();
        bus.stall = 1'b0;
        bus.imem_ready = 1'b1;
        next_cycle();
        rst = 1'b0;
        m_pc = RST_PC;
        m_bub = 0;
        m_init = 1'b1;
        for (int i = 0; i < 16; i++) begin
            m_ctr[i] = 1; m_val[i] = 1'b0; m_tgt[i] = '0; m_bpc[i] = '0;
        end
        for (int n = 0; n < 600; n++) begin
            bus.stall      = ($urandom_range(0, 3) == 0);
            bus.imem_ready = ($urandom_range(0, 4) != 0);
            r_valid = ($urandom_range(0, 3) == 0);
            r_br    = 1'($urandom_range(0, 1));
            r_tk    = 1'($urandom_range(0, 1));
            r_pc    = 32'h100 + 32'($urandom_range(0, 31) << 2);
            r_tgt   = 32'h100 + 32'($urandom_range(0, 63) << 2);
            if ($urandom_range(0, 19) == 0) begin
                r_pc = 32'hFFFF_FFFC;
                r_tk = 1'b0;
            end
            act  = r_tk ? r_tgt : r_pc + 32'd4;
            r_pn = ($urandom_range(0, 2) == 0) ? (act ^ 32'h10) : act;
            if (r_valid) set_resolve(r_pc, r_br, r_tk, r_tgt, r_pn);
            else clear_resolve();
            mp = r_valid && (act != r_pn);
            exp_pred = m_pc + 32'd4;
`ifdef BP_BHT_EN
            idx = int'(m_pc[5:2]);
            if (m_val[idx] && m_bpc[idx] == m_pc && m_ctr[idx] >= 2) exp_pred = m_tgt[idx];
`endif
            exp_valid = !m_init && (m_bub == 0);
            #1;
            checks++;
            if (bus.pc !== m_pc || bus.fetch_valid !== exp_valid || bus.flush !== mp || bus.pred_next !== exp_pred) begin
                failures++;
                $display("FAIL rand%0d pc=%h valid=%b flush=%b pred=%h expected pc=%h valid=%b flush=%b pred=%h",
                         n, bus.pc, bus.fetch_valid, bus.flush, bus.pred_next, m_pc, exp_valid, mp, exp_pred);
            end
            if (m_init) m_init = 1'b0;
            else if (mp) begin m_pc = act; m_bub = FLUSH; end
            else if (m_bub > 0) m_bub--;
            else if (!bus.stall && bus.imem_ready) m_pc = exp_pred;
`ifdef BP_BHT_EN
            if (r_valid && r_br) begin
                idx = int'(r_pc[5:2]);
                if (r_tk) begin
                    m_ctr[idx] = (m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3;
                    m_tgt[idx] = r_tgt; m_bpc[idx] = r_pc; m_val[idx] = 1'b1;
                end else begin
                    m_ctr[idx] = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
                end
            end
`endif
            next_cycle();
        end
        clear_resolve();
    endtask

    initial begin
        rst = 1'b1;
        bus.stall = 1'b0;
        bus.imem_ready = 1'b1;
        clear_resolve();
        @(negedge clk);
        test_reset();
        test_stall();
        test_redirect();
        test_recover_redirect();
        test_predictor();
        test_reset_in_recover();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_fetch_sequencer.md
# pc_fetch_sequencer

Fetch-stage controller that owns the program counter and sequences instruction fetch around the branch predictor. Each cycle it selects the next PC from the sequential/predicted path, holds on stall or instruction-memory backpressure, and redirects on branch mispredictions reported by execute. It sits between the instruction memory and the IF/ID pipeline register, and drives the flush that squashes wrong-path instructions.

## Interface

- PC_W, 32, program-counter width in bits
- RESET_PC, 32'h0000_0000, PC loaded on reset
- FLUSH_CYCLES, 2, fetch bubbles after a redirect (legal 1..7)
- BHT_ENTRIES, 16, predictor table depth (power of two; used only with BP_BHT_EN)

- Clk  in  1  clock, rising edge
- Rst  in  1  asynchronous, active-high reset
- Stall  in  1  hazard stall from decode; hold PC
- ImemReady  in  1  instruction memory accepts the fetch address this cycle
- PC  out  PC_W  current fetch address
- FetchValid  out  1  PC is a valid fetch this cycle
- PredNext  out  PC_W  predicted next PC for PC; carried down the pipeline
- ResolveValid  in  1  execute is resolving a control instruction this cycle
- ResolveIsBranch  in  1  resolved instruction is a conditional branch
- ResolvePC  in  PC_W  address of the resolved instruction
- ResolveTaken  in  1  actual direction
- ResolveTarget  in  PC_W  actual taken target
- ResolvePredNext  in  PC_W  PredNext that travelled with the instruction
- Flush  out  1  squash IF/ID and ID/EX this cycle

## Operation

- ActualNext = ResolveTaken ? ResolveTarget : ResolvePC + 4 (mod 2^PC_W).
- Mispredict = ResolveValid && (ActualNext != ResolvePredNext). Flush = Mispredict (combinational, same cycle).
- States: INIT, RUN, HOLD, RECOVER.
- INIT: entered on reset; FetchValid=0; next cycle → RUN.
- RUN: FetchValid=1. Priority: Mispredict > Stall/!ImemReady > advance.
  - Mispredict: PC<=ActualNext, counter<=FLUSH_CYCLES-1, → RECOVER.
  - Stall or !ImemReady: PC held, → HOLD.
  - Otherwise PC<=PredNext.
- HOLD: FetchValid=1, PC held; Mispredict → redirect as above; when Stall=0 and ImemReady=1, PC<=PredNext, → RUN.
- RECOVER: FetchValid=0, PC held at redirect target; counter decrements each cycle; at 0 → RUN. Mispredict inside RECOVER reloads PC and counter.
- PC+4 wraps modulo 2^PC_W; no overflow detection.
- Reset outputs: PC=RESET_PC, FetchValid=0, Flush=0 (ResolveValid masked during Rst), state INIT, counter 0.

## Timing

- PC is registered; PredNext and Flush are combinational from current-cycle inputs/state.
- Redirect latency: Mispredict at cycle t → PC=ActualNext at t+1, FetchValid=0 for t+1..t+FLUSH_CYCLES, first valid fetch at t+FLUSH_CYCLES+1.
- Stall takes effect at the same edge: PC at t+1 equals PC at t.
- Reset mid-operation aborts RECOVER/HOLD immediately; predictor state also reset.

## Configuration

- BP_BHT_EN defined: direct-mapped table of BHT_ENTRIES 2-bit saturating counters plus target/tag/valid per entry, indexed by PC[log2(BHT_ENTRIES)+1:2]. PredNext = target if valid, tag match and counter>=2, else PC+4. On ResolveValid&&ResolveIsBranch: counter ++ (sat 3) if taken, -- (sat 0) if not; if taken, write target, tag, valid. Reset: counters=2'b01, valid=0. Read-after-write same index: read sees old value.
- BP_BHT_EN undefined: PredNext = PC+4 always (static not-taken); table not instantiated; ResolveIsBranch ignored.

## Structure

- Shared package: state enum (INIT/RUN/HOLD/RECOVER), 2-bit counter constants (SNT, WNT, WT, ST), default RESET_PC.
- Sub-module: branch_history_table (counters, BTB, lookup/update), instantiated only under BP_BHT_EN.

## Test plan

- Reset with RESET_PC=0x100 → PC=0x100, FetchValid=0 one cycle, then 0x100, 0x104, 0x108 fetched in RUN.
- Stall=1 for 3 cycles at PC=0x108 → PC stays 0x108, FetchValid=1; release → 0x10C next cycle.
- ResolveValid, ResolvePC=0x104, Taken=1, Target=0x200, PredNext=0x108 → Flush=1 that cycle, PC=0x200 next, FetchValid=0 for 2 cycles, then 0x200, 0x204.
- Second mispredict (target 0x300) during RECOVER → PC=0x300, bubble counter restarts at 2.
- BP_BHT_EN: resolve branch at 0x120 taken to 0x400 twice → next fetch of 0x120 gives PredNext=0x400; one not-taken resolve → PredNext still 0x400 (counter 2); second not-taken → PredNext=0x124.
- Assert Rst during RECOVER → PC=RESET_PC, FetchValid=0, Flush=0 immediately; predictor cleared (0x120 predicts 0x124).
